// File: rtl/vga_timing_controller_if.sv
// Raster timing bundle between vga_timing_controller (master) and the pixel
// generator / DAC side (slave).
interface vga_timing_controller_if;
  logic        enable;
  logic        enable_V_Counter;
  logic        frame_end;
  logic [15:0] H_Count_Value;
  logic [15:0] V_Count_Value;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic [7:0]  frame_count;

  modport master (
    input  enable,
    output enable_V_Counter, frame_end, H_Count_Value, V_Count_Value,
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_count
  );

  modport slave (
    output enable,
    input  enable_V_Counter, frame_end, H_Count_Value, V_Count_Value,
    input  hsync, vsync, video_on, pixel_x, pixel_y, frame_count
  );
endinterface

// File: rtl/vga_timing_controller.sv
// 640x480@60 raster timing: H/V counters, per-axis phase FSMs, registered sync/video outputs.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_controller #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                   clk_25Mhz,
  input  logic                   rst,
  vga_timing_controller_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the FSM leaves the phase on the enabled cycle at that count.
  localparam logic [15:0] HActLast  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HFpLast   = 16'(H_ACTIVE + H_FP - 1);
  localparam logic [15:0] HSyncLast = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] HTotLast  = 16'(H_TOTAL - 1);
  localparam logic [15:0] VActLast  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VFpLast   = 16'(V_ACTIVE + V_FP - 1);
  localparam logic [15:0] VSyncLast = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [15:0] VTotLast  = 16'(V_TOTAL - 1);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} phase_e;

  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  phase_e      h_state_q, h_state_d, v_state_q, v_state_d;
  logic        hsync_q, vsync_q, video_on_q;
  logic [15:0] pixel_x_q, pixel_y_q;
  logic        line_end, frame_last;

  assign line_end   = vga.enable && (h_cnt_q == HTotLast);
  assign frame_last = line_end && (v_cnt_q == VTotLast);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.enable) begin
      h_cnt_d = (h_cnt_q == HTotLast) ? 16'd0 : h_cnt_q + 16'd1;
    end
    if (line_end) begin
      v_cnt_d = (v_cnt_q == VTotLast) ? 16'd0 : v_cnt_q + 16'd1;
    end
  end

  always_comb begin
    h_state_d = h_state_q;
    if (vga.enable) begin
      unique case (h_state_q)
        StActive: if (h_cnt_q == HActLast)  h_state_d = StFront;
        StFront:  if (h_cnt_q == HFpLast)   h_state_d = StSync;
        StSync:   if (h_cnt_q == HSyncLast) h_state_d = StBack;
        StBack:   if (h_cnt_q == HTotLast)  h_state_d = StActive;
        default:  h_state_d = StActive;
      endcase
    end
  end

  // Vertical phase only moves on the line-end strobe.
  always_comb begin
    v_state_d = v_state_q;
    if (line_end) begin
      unique case (v_state_q)
        StActive: if (v_cnt_q == VActLast)  v_state_d = StFront;
        StFront:  if (v_cnt_q == VFpLast)   v_state_d = StSync;
        StSync:   if (v_cnt_q == VSyncLast) v_state_d = StBack;
        StBack:   if (v_cnt_q == VTotLast)  v_state_d = StActive;
        default:  v_state_d = StActive;
      endcase
    end
  end

  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      h_cnt_q   <= 16'd0;
      v_cnt_q   <= 16'd0;
      h_state_q <= StActive;
      v_state_q <= StActive;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  // Outputs describe the counts present on the previous enabled cycle.
  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      pixel_x_q  <= 16'd0;
      pixel_y_q  <= 16'd0;
    end else if (vga.enable) begin
      hsync_q    <= (h_state_q != StSync);
      vsync_q    <= (v_state_q != StSync);
      video_on_q <= (h_state_q == StActive) && (v_state_q == StActive);
      pixel_x_q  <= h_cnt_q;
      pixel_y_q  <= v_cnt_q;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      frame_count_q <= 8'd0;
    end else if (frame_last) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vga.frame_count = frame_count_q;
`else
  assign vga.frame_count = 8'd0;
`endif

  assign vga.enable_V_Counter = line_end;
  assign vga.frame_end        = frame_last;
  assign vga.H_Count_Value    = h_cnt_q;
  assign vga.V_Count_Value    = v_cnt_q;
  assign vga.hsync            = hsync_q;
  assign vga.vsync            = vsync_q;
  assign vga.video_on         = video_on_q;
  assign vga.pixel_x          = pixel_x_q;
  assign vga.pixel_y          = pixel_y_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a default 640x480 instance and a shrunken-geometry instance
// share clock/reset/enable and are checked every cycle against an arithmetic raster model.
module tb_vga_timing_controller;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  always #20 clk = ~clk;

  vga_timing_controller_if if_big ();
  vga_timing_controller_if if_small ();

  assign if_big.enable   = enable;
  assign if_small.enable = enable;

  vga_timing_controller u_big (
    .clk_25Mhz (clk),
    .rst       (rst),
    .vga       (if_big)
  );

  vga_timing_controller #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) u_small (
    .clk_25Mhz (clk),
    .rst       (rst),
    .vga       (if_small)
  );

  // Geometry per model: index 0 = default instance, 1 = small instance.
  longint unsigned ha [2] = '{640, 16};
  longint unsigned hf [2] = '{16, 4};
  longint unsigned hs [2] = '{96, 6};
  longint unsigned hb [2] = '{48, 4};
  longint unsigned va [2] = '{480, 8};
  longint unsigned vf [2] = '{10, 2};
  longint unsigned vs [2] = '{2, 2};
  longint unsigned vb [2] = '{33, 3};
  string           nm [2] = '{"big", "small"};

  // Model state: enabled cycles since reset, and the expected frame counter.
  longint unsigned n   [2];
  int unsigned     fcm [2];

  int tests = 0;
  int fails = 0;
  int big_lines = 0;
  int small_frames = 0;

  function automatic longint unsigned htot(input int d);
    return ha[d] + hf[d] + hs[d] + hb[d];
  endfunction

  function automatic longint unsigned vtot(input int d);
    return va[d] + vf[d] + vs[d] + vb[d];
  endfunction

  function automatic longint unsigned hpos(input int d);
    return n[d] % htot(d);
  endfunction

  function automatic longint unsigned vpos(input int d);
    return (n[d] / htot(d)) % vtot(d);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic evc, input logic fe,
                           input logic [15:0] hc, input logic [15:0] vc,
                           input logic hsy, input logic vsy, input logic von,
                           input logic [15:0] px, input logic [15:0] py,
                           input logic [7:0] fcv);
    longint unsigned ht, vt, h, v, ph, pv;
    logic e_evc, e_fe, e_hs, e_vs, e_von;
    ht = htot(d);
    vt = vtot(d);
    h  = hpos(d);
    v  = vpos(d);
    e_evc = enable && (h == ht - 1);
    e_fe  = e_evc && (v == vt - 1);
    if (n[d] == 0) begin
      ph = 0; pv = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0;
    end else begin
      ph = (n[d] - 1) % ht;
      pv = ((n[d] - 1) / ht) % vt;
      e_hs  = !(ph >= ha[d] + hf[d] && ph < ha[d] + hf[d] + hs[d]);
      e_vs  = !(pv >= va[d] + vf[d] && pv < va[d] + vf[d] + vs[d]);
      e_von = (ph < ha[d]) && (pv < va[d]);
    end
    chk({nm[d], " H_Count"},   longint'(hc),  longint'(h));
    chk({nm[d], " V_Count"},   longint'(vc),  longint'(v));
    chk({nm[d], " enable_V"},  longint'(evc), longint'(e_evc));
    chk({nm[d], " frame_end"}, longint'(fe),  longint'(e_fe));
    chk({nm[d], " hsync"},     longint'(hsy), longint'(e_hs));
    chk({nm[d], " vsync"},     longint'(vsy), longint'(e_vs));
    chk({nm[d], " video_on"},  longint'(von), longint'(e_von));
    chk({nm[d], " pixel_x"},   longint'(px),  longint'(ph));
    chk({nm[d], " pixel_y"},   longint'(py),  longint'(pv));
`ifdef VGA_FRAME_COUNT_EN
    chk({nm[d], " frame_count"}, longint'(fcv), longint'(fcm[d] & 8'hff));
`else
    chk({nm[d], " frame_count"}, longint'(fcv), 0);
`endif
  endtask

  // One clock: check at negedge, advance the model at posedge, return 1 time unit later.
  task automatic step();
    @(negedge clk);
    check_dut(0, if_big.enable_V_Counter, if_big.frame_end, if_big.H_Count_Value,
              if_big.V_Count_Value, if_big.hsync, if_big.vsync, if_big.video_on,
              if_big.pixel_x, if_big.pixel_y, if_big.frame_count);
    check_dut(1, if_small.enable_V_Counter, if_small.frame_end, if_small.H_Count_Value,
              if_small.V_Count_Value, if_small.hsync, if_small.vsync, if_small.video_on,
              if_small.pixel_x, if_small.pixel_y, if_small.frame_count);
    if (if_big.enable_V_Counter) big_lines++;
    if (if_small.frame_end) small_frames++;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        n[d]   = 0;
        fcm[d] = 0;
      end else if (enable) begin
        if (hpos(d) == htot(d) - 1 && vpos(d) == vtot(d) - 1) fcm[d] = (fcm[d] + 1) & 8'hff;
        n[d]++;
      end
    end
    #1;
  endtask

  // Advance with enable high until the small instance sits at (h, v); bounded.
  task automatic seek_small(input longint unsigned h, input longint unsigned v, input string tag);
    int guard = 0;
    enable = 1'b1;
    while (!(hpos(1) == h && vpos(1) == v) && guard < 1000) begin
      step();
      guard++;
    end
    chk({tag, " reached"}, longint'(guard < 1000), 1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    n      = '{0, 0};
    fcm    = '{0, 0};
    @(posedge clk);
    @(posedge clk);
    #1;
    step();
    step();

    // First line on the default geometry: exactly one line-end strobe in 800 cycles.
    rst = 1'b0;
    big_lines = 0;
    repeat (800) step();
    chk("big line strobes per line", big_lines, 1);
    chk("big V after one line", longint'(if_big.V_Count_Value), 1);
    repeat (50) step();

    // Hold in mid-vsync on the small geometry, then resume.
    seek_small(20, 10, "hold point");
    enable = 1'b0;
    repeat (50) step();
    enable = 1'b1;
    repeat (20) step();

    // Reset mid-vsync.
    seek_small(20, 11, "reset point");
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();

    // Three whole small frames with enable held high.
    small_frames = 0;
    repeat (3 * 450) step();
    chk("small frame_end pulses", small_frames, 3);

    // Randomised enable gaps and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(7) != 0);
      rst    = ($urandom_range(599) == 0);
      step();
    end
    rst    = 1'b0;
    enable = 1'b1;
    repeat (1000) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Raster timing controller for the 640x480@60 Hz VGA output. It sequences the horizontal and vertical pixel counters from the 25 MHz pixel clock. It generates the line-end strobe that advances the vertical count, decodes per-axis porch/sync/active phases with small state machines, and drives registered hsync, vsync, video_on and pixel coordinates to the pixel generator and DAC/connector.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- Derived: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525

Ports:
- clk_25Mhz  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  run/hold; when 0, all counters, states and outputs hold
- enable_V_Counter  out  1  combinational line-end strobe = enable && H_Count_Value == H_TOTAL-1
- frame_end  out  1  combinational = enable_V_Counter && V_Count_Value == V_TOTAL-1
- H_Count_Value  out  16  horizontal counter, 0..H_TOTAL-1
- V_Count_Value  out  16  vertical counter, 0..V_TOTAL-1
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- video_on  out  1  registered, high only in the visible region
- pixel_x  out  16  registered, equals H count of the pixel being described
- pixel_y  out  16  registered, equals V count of the pixel being described
- frame_count  out  8  registered frame counter; see Configuration

## Operation
- Counters:
  - H increments by 1 each enabled cycle and wraps H_TOTAL-1 -> 0.
  - V increments only on enable_V_Counter and wraps V_TOTAL-1 -> 0 in the same cycle H wraps.
- Per-axis FSM with states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE:
  - H FSM transitions on enabled cycles when the H count sits at its phase boundary: H count 639 -> FRONT, 655 -> SYNC, 751 -> BACK, 799 -> ACTIVE.
  - V FSM uses the same rule but advances only on enable_V_Counter: V count 479 -> FRONT, 489 -> SYNC, 491 -> BACK, 524 -> ACTIVE.
- Invariant: the FSM state always matches the range containing the current count (ACTIVE 0..639/0..479, FRONT 640..655/480..489, SYNC 656..751/490..491, BACK 752..799/492..524).
- Output decode, registered on enabled cycles from the current state and counts:
  - hsync = !(hstate==SYNC)
  - vsync = !(vstate==SYNC)
  - video_on = hstate==ACTIVE && vstate==ACTIVE
  - pixel_x = H count; pixel_y = V count
- Arithmetic: 16-bit unsigned throughout; counts never exceed TOTAL-1.
- Reset, from any state including mid-line or mid-sync:
  - H count = 0, V count = 0, both FSMs ACTIVE
  - hsync = 1, vsync = 1, video_on = 0, pixel_x = 0, pixel_y = 0, frame_count = 0
- enable low: no state changes; enable_V_Counter and frame_end are forced 0.
- rst has priority over enable.

## Timing
- Counter-to-output latency is 1 enabled cycle. Registered outputs in cycle n+1 describe counts H(n)/V(n).
- After reset release with enable=1:
  - cycle 0: counts 0,0 and outputs still at reset values
  - cycle 1: video_on=1, pixel_x=0, pixel_y=0
- enable_V_Counter is high for exactly 1 cycle per line (every 800 enabled cycles).
- frame_end is high for 1 cycle per frame (every 420000 enabled cycles).
- Sync pulse widths: hsync low for 96 consecutive enabled cycles; vsync low for 2 lines = 1600 enabled cycles.
- Sync alignment:
  - hsync falls at output cycle describing H=656
  - vsync falls at output describing V=490, H=0

## Configuration
- VGA_FRAME_COUNT_EN defined: frame_count increments by 1 (mod 256) in the cycle after frame_end is high. It is reset to 0 and holds while enable=0.
- Not defined: frame_count is driven constant 0 and no counter register is synthesised. All other behaviour is identical.

## Test plan
- Reset then enable=1 for 800 cycles: H counts 0..799 then 0; enable_V_Counter high only at H=799; V goes 0->1.
- Full line check: hsync low exactly for pixel_x 656..751 (96 cycles); video_on high exactly for pixel_x 0..639 while pixel_y < 480.
- Full frame, 420000 cycles: vsync low for pixel_y 490..491 only; frame_end single pulse at H=799, V=524; then V=0, H=0. With VGA_FRAME_COUNT_EN, frame_count goes 0->1.
- Drop enable at H=700, V=491 for 50 cycles: all counts, states and outputs frozen, enable_V_Counter = 0. Resuming continues at H=701 with vsync still low.
- Assert rst at H=700, V=491 (mid-vsync): next cycle H=0, V=0, hsync=1, vsync=1, video_on=0, frame_count=0.
- Without VGA_FRAME_COUNT_EN, run 3 frames: frame_count stays 0 and all other outputs match the macro-enabled run cycle for cycle.
